// File: rtl/button_event_decoder_if.sv
// Button event bundle between the conditioned button level and
// the event consumers (control FSMs, menus).
interface button_event_decoder_if #(
  parameter int COUNT_WIDTH = 8
);
  logic                   btn_level;
  logic                   press_pulse;
  logic                   release_pulse;
  logic                   long_press_pulse;
  logic                   repeat_pulse;
  logic                   held;
  logic [COUNT_WIDTH-1:0] press_count;

  modport master (
    output btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_press_pulse,
    input  repeat_pulse,
    input  held,
    input  press_count
  );

  modport slave (
    input  btn_level,
    output press_pulse,
    output release_pulse,
    output long_press_pulse,
    output repeat_pulse,
    output held,
    output press_count
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a clean button level into one-cycle press/release/long/repeat
// events plus a held level and a wrapping press counter.
module button_event_decoder #(
  parameter int LONG_PRESS_CYCLES = 16,
  parameter int REPEAT_CYCLES     = 8,
  parameter int CNT_WIDTH         = 8,
  parameter int COUNT_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  button_event_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    PRESSED,
    LONG_HELD
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LONG_LAST =
    CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REP_LAST =
    CNT_WIDTH'(REPEAT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] T_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] T_ONE  = CNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] C_ONE = COUNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   timer_q, timer_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   press_q, press_d;
  logic                   rel_q, rel_d;
  logic                   long_q, long_d;
  logic                   rep_q, rep_d;
  logic                   held_q, held_d;
  logic                   btn;

  assign btn = bus.btn_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARM;
      timer_q <= '0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      held_q  <= held_d;
    end
  end

  // Release is tested first so it always wins over long/repeat.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    held_d  = held_q;
    unique case (state_q)
      ARM: begin
        held_d = 1'b0;
        if (!btn) begin
          state_d = IDLE;
          timer_d = T_ZERO;
        end
      end
      IDLE: begin
        if (btn) begin
          state_d = PRESSED;
          timer_d = T_ZERO;
          press_d = 1'b1;
          held_d  = 1'b1;
          cnt_d   = cnt_q + C_ONE;
        end
      end
      PRESSED: begin
        if (!btn) begin
          state_d = IDLE;
          timer_d = T_ZERO;
          rel_d   = 1'b1;
          held_d  = 1'b0;
        end else if (timer_q == LONG_LAST) begin
          state_d = LONG_HELD;
          timer_d = T_ZERO;
          long_d  = 1'b1;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      LONG_HELD: begin
        if (!btn) begin
          state_d = IDLE;
          timer_d = T_ZERO;
          rel_d   = 1'b1;
          held_d  = 1'b0;
        end else if (timer_q == REP_LAST) begin
          timer_d = T_ZERO;
          rep_d   = 1'b1;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      default: begin
        state_d = ARM;
        timer_d = T_ZERO;
        held_d  = 1'b0;
      end
    endcase
  end

  assign bus.press_pulse      = press_q;
  assign bus.release_pulse    = rel_q;
  assign bus.long_press_pulse = long_q;
  assign bus.repeat_pulse     = rep_q;
  assign bus.held             = held_q;
  assign bus.press_count      = cnt_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with L=16, R=8.
module tb_button_event_decoder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  button_event_decoder_if #(.COUNT_WIDTH(8)) bus ();

  button_event_decoder #(
    .LONG_PRESS_CYCLES(16),
    .REPEAT_CYCLES(8),
    .CNT_WIDTH(8),
    .COUNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic b);
    bus.btn_level = b;
    @(posedge clk);
    #1;
  endtask

  function automatic int outs();
    return {28'd0, bus.press_pulse, bus.release_pulse,
            bus.long_press_pulse, bus.repeat_pulse};
  endfunction

  // btn high at edges 0..h-1, low from edge h; cycle c = edge+1
  task automatic run_press(input string tag, input int h,
                           input int e_rel, input int e_long,
                           input int e_nrep, input int e_rep1,
                           input int e_repn);
    int p_at, r_at, l_at, np, nr, nl, nrep, rep1, repn, heldn, multi;
    int c;
    p_at = 0; r_at = 0; l_at = 0;
    np = 0; nr = 0; nl = 0;
    nrep = 0; rep1 = 0; repn = 0;
    heldn = 0; multi = 0;
    for (int e = 0; e <= h + 3; e++) begin
      step(e < h);
      c = e + 1;
      if (bus.press_pulse) begin np++; p_at = c; end
      if (bus.release_pulse) begin nr++; r_at = c; end
      if (bus.long_press_pulse) begin nl++; l_at = c; end
      if (bus.repeat_pulse) begin
        nrep++;
        if (rep1 == 0) rep1 = c;
        repn = c;
      end
      if (bus.held) heldn++;
      if ($countones(outs()) > 1) multi++;
    end
    exp_cnt = (exp_cnt + 1) % 256;
    chk({tag, "_press_at"}, p_at, 1);
    chk({tag, "_npress"}, np, 1);
    chk({tag, "_rel_at"}, r_at, e_rel);
    chk({tag, "_nrel"}, nr, 1);
    chk({tag, "_long_at"}, l_at, e_long);
    chk({tag, "_nlong"}, nl, (e_long != 0) ? 1 : 0);
    chk({tag, "_nrep"}, nrep, e_nrep);
    chk({tag, "_rep1"}, rep1, e_rep1);
    chk({tag, "_repn"}, repn, e_repn);
    chk({tag, "_held"}, heldn, h);
    chk({tag, "_multi"}, multi, 0);
    chk({tag, "_count"}, int'(bus.press_count), exp_cnt);
  endtask

  initial begin
    int np, nr;
    bus.btn_level = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", outs(), 0);
    chk("rst_held", int'(bus.held), 0);
    chk("rst_count", int'(bus.press_count), 0);
    reset_n = 1'b1;
    repeat (3) step(1'b0);

    step(1'b1);
    chk("first_press", int'(bus.press_pulse), 1);
    chk("first_held", int'(bus.held), 1);
    chk("first_count", int'(bus.press_count), 1);
    step(1'b1);
    chk("first_press_gone", int'(bus.press_pulse), 0);
    repeat (3) step(1'b0);
    exp_cnt = 1;

    run_press("short", 5, 6, 0, 0, 0, 0);
    run_press("long", 41, 42, 17, 3, 25, 41);
    run_press("edge", 16, 17, 0, 0, 0, 0);
    run_press("min", 1, 2, 0, 0, 0, 0);

    // reset while the button is still held
    step(1'b1);
    step(1'b1);
    step(1'b1);
    chk("mid_held_pre", int'(bus.held), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_outs", outs(), 0);
    chk("mid_held", int'(bus.held), 0);
    chk("mid_count", int'(bus.press_count), 0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    np = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      np += int'(bus.press_pulse) + int'(bus.held);
    end
    chk("arm_no_press", np, 0);
    step(1'b0);
    step(1'b1);
    chk("arm_press", int'(bus.press_pulse), 1);
    chk("arm_count", int'(bus.press_count), 1);
    repeat (3) step(1'b0);

    // press counter wrap
    #2 reset_n = 1'b0;
    #4 reset_n = 1'b1;
    step(1'b0);
    step(1'b0);
    np = 0;
    nr = 0;
    for (int i = 1; i <= 256; i++) begin
      step(1'b1);
      np += int'(bus.press_pulse);
      step(1'b0);
      nr += int'(bus.release_pulse);
      if (i == 255) chk("wrap_255", int'(bus.press_count), 255);
      if (i == 256) chk("wrap_0", int'(bus.press_count), 0);
    end
    chk("wrap_npress", np, 256);
    chk("wrap_nrel", nr, 256);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
Consumes the clean, synchronous level produced by the team's debouncer/synchronizer and turns it into single-cycle button events: press, release, long-press and auto-repeat. It also reports a held level and a wrapping press counter. It sits between the input-conditioning stage and the control FSMs and menus that react to user buttons.

Parameters:
LONG_PRESS_CYCLES, 16, clock edges btn_level must stay high after the press edge before long_press_pulse fires (>=2)
REPEAT_CYCLES, 8, clock edges between repeat_pulse events once long-held (>=1)
CNT_WIDTH, 8, width of the internal hold timer; must hold max(LONG_PRESS_CYCLES, REPEAT_CYCLES)-1
COUNT_WIDTH, 8, width of press_count

Ports:
clk  input  1  system clock; all logic on posedge
reset_n  input  1  asynchronous, active-low reset
btn_level  input  1  debounced button level, already synchronous to clk; 1 = pressed
press_pulse  output  1  one-cycle pulse on a new press
release_pulse  output  1  one-cycle pulse on release
long_press_pulse  output  1  one-cycle pulse when a press becomes a long press
repeat_pulse  output  1  one-cycle pulse at each auto-repeat interval while long-held
held  output  1  high from the press_pulse cycle through the cycle before release_pulse
press_count  output  COUNT_WIDTH  number of accepted presses, modulo 2^COUNT_WIDTH

Behaviour:
- All outputs are registered. Reset drives every output to 0, the timer to 0, and the state to ARM, asynchronously.
- States: ARM, IDLE, PRESSED, LONG_HELD.
- ARM: waits for btn_level sampled 0, then moves to IDLE with no outputs. A button held through reset produces no event until it has been released.
- IDLE: btn_level sampled 1 at edge e0 leads to:
  - press_pulse=1 and held=1 in the following cycle;
  - press_count+1, wrapping from all-ones to 0;
  - timer cleared; state moves to PRESSED.
- PRESSED:
  - btn_level sampled 0: release_pulse=1 and held=0 next cycle; state moves to IDLE.
  - btn_level sampled 1: timer increments.
  - At the edge where timer==LONG_PRESS_CYCLES-1 and btn_level=1, i.e. edge e0+LONG_PRESS_CYCLES: long_press_pulse=1 next cycle, timer cleared, state moves to LONG_HELD.
- LONG_HELD:
  - btn_level sampled 0: release_pulse and return to IDLE.
  - At each edge where timer==REPEAT_CYCLES-1 and btn_level=1: repeat_pulse=1 next cycle and timer cleared. Repeats therefore occur at e0+L+R, e0+L+2R, ...
  - With REPEAT_CYCLES=1, repeat_pulse stays high every cycle while held.
- Release has priority: if btn_level is 0 on the edge that would fire long or repeat, only release_pulse is generated.
- Pulses are exactly one cycle wide. At most one of press/release/long/repeat is high in any cycle.
- Minimum press: high for one edge, then low. press_pulse and release_pulse appear in consecutive cycles.
- Timer never wraps: it is cleared on every state change and on every long/repeat event.
- Reset mid-press: outputs clear immediately, no release_pulse is emitted, and the block returns to ARM.
- Latency: one cycle from the sampling edge to any output.

Test Plan:
Use L=16, R=8.
- reset, btn_level=0 for 3 cycles, then 1 sampled at edge e0 -> press_pulse high in cycle e0+1 only, held=1, press_count=1.
- btn high for edges e0..e0+4, low at e0+5 -> press_pulse at e0+1, release_pulse at e0+6, held low from e0+6, no long or repeat.
- btn high for edges e0..e0+40, low at e0+41 -> long_press_pulse at e0+17; repeat_pulse at e0+25, e0+33 and e0+41 (3 repeats); release_pulse at e0+42.
- btn high for edges e0..e0+15, low at e0+16 (release on the long edge) -> release_pulse at e0+17, no long_press_pulse.
- reset asserted mid-press with btn still high -> all outputs 0 immediately; no press until btn is sampled 0 and then 1 again; press_count restarts at 1.
- 256 short presses with COUNT_WIDTH=8 -> press_count reads 255 after the 255th press and 0 after the 256th; each press yields exactly one press_pulse and one release_pulse.
